estacao_reserva_r: RTL
======================

ESTACAO_RESERVA_R -- requirements
Module: estacao_reserva_r

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 2, number of reservation entries (1..4).
REQ-002 SHALL have parameter TAG_BASE, default 3'd1, tag of entry 0; entry i has tag TAG_BASE+i; tag 0 = "operand valid".
REQ-003 SHALL have parameter TIMEOUT, default 8, max EXEC cycles without UF_Done before abort.
REQ-004 Clock  in  1  single clock; all state updates on posedge Clock.
REQ-005 Reset  in  1  reset, synchronous and active-high.
REQ-006 Issue_valid  in  1  issue request, one-cycle qualifier.
REQ-007 Issue_op  in  3  Ufop code to store.
REQ-008 Issue_Vj, Issue_Vk  in  16 each  operand values (used when matching Q = 0).
REQ-009 Issue_Qj, Issue_Qk  in  3 each  producer tags; 0 = value valid.
REQ-010 Issue_ready  out  1  at least one free entry (from registered state).
REQ-011 Issue_tag  out  3  tag of lowest-index free entry; 0 when full.
REQ-012 CDB_valid  in  1, CDB_tag  in  3, CDB_data  in  16  common data bus broadcast.
REQ-013 Ready_to_uf  out  1, A, B  out  16 each, Ufop  out  3  functional-unit drive.
REQ-014 Clear_uf  out  1  one-cycle clear pulse to functional unit.
REQ-015 UF_Done  in  1  functional unit completion.
REQ-016 Exec_tag  out  3  tag of entry in execution; 0 when idle.
REQ-017 Timeout_err  out  1  one-cycle pulse on EXEC abort.

Function
REQ-018 Entry state: Busy, Op, Vj, Vk, Qj, Qk.
REQ-019 Issue accepted iff Issue_valid=1, Issue_ready=1 and Issue_op in {010,011,110,111}; otherwise ignored, no state change.
REQ-020 Accepted issue writes lowest-index free entry, Busy=1, on same edge.
REQ-021 Issue bypass: if CDB_valid=1 and CDB_tag=Issue_Qj (nonzero) in same cycle, entry stores Vj=CDB_data, Qj=0; same for k.
REQ-022 Capture: each Busy entry with Qj=CDB_tag≠0 and CDB_valid=1 loads Vj=CDB_data, Qj=0 on the edge; same for k; all matching entries capture simultaneously.
REQ-023 Entry ready = Busy & Qj=0 & Qk=0 (registered values).
REQ-024 FSM states IDLE, EXEC, CLEAR.
REQ-025 IDLE: if any entry ready and not being issued this cycle, select lowest-index ready entry, latch A=Vj, B=Vk, Ufop=Op, Exec_tag, set Ready_to_uf=1, go EXEC; else stay.
REQ-026 Operands ready at edge N -> Ready_to_uf high after edge N+1 (one-cycle dispatch latency).
REQ-027 EXEC: hold Ready_to_uf, A, B, Ufop, Exec_tag stable; count cycles.
REQ-028 EXEC with UF_Done=1: free entry (Busy=0), Ready_to_uf=0, Clear_uf=1, Exec_tag=0, go CLEAR.
REQ-029 EXEC with count reaching TIMEOUT and UF_Done=0: same as REQ-028 plus Timeout_err=1 for one cycle.
REQ-030 CLEAR: Clear_uf=0, go IDLE; no dispatch this cycle.
REQ-031 Entry freed on edge N is reported in Issue_ready/Issue_tag only after edge N.
REQ-032 Entry in execution never re-dispatched; CDB capture into it is ignored (Qj=Qk=0 already).
REQ-033 Issue while full: dropped, Issue_ready stays 0, no error.

Reset
REQ-034 Reset=1 at posedge: all Busy=0, V/Q=0, FSM=IDLE, Ready_to_uf=0, A=B=0, Ufop=000, Clear_uf=0, Exec_tag=0, Timeout_err=0, counter=0.
REQ-035 Reset overrides issue, capture and UF_Done in the same cycle, including mid-EXEC.
REQ-036 After reset: Issue_ready=1, Issue_tag=TAG_BASE.

Verification
REQ-037 Issue op=010, Vj=5, Vk=7, Qj=Qk=0 -> Ready_to_uf high next cycle with A=5, B=7, Ufop=010, Exec_tag=1; UF_Done -> Clear_uf pulse, Issue_ready=1.
REQ-038 Issue op=011, Qj=3, Vk=2; later CDB_valid, tag=3, data=9 -> Vj=9, dispatch A=9, B=2 one cycle after capture.
REQ-039 Issue with Qj=3 while CDB broadcasts tag=3, data=4 same cycle -> entry stores Vj=4, Qj=0 (bypass).
REQ-040 Fill both entries, third Issue_valid -> Issue_ready=0, Issue_tag=0, third ignored; both ready -> entry 0 (tag 1) dispatched first.
REQ-041 Dispatch op=111, hold UF_Done=0 -> after 8 EXEC cycles Timeout_err pulse, entry freed, FSM back to IDLE via CLEAR.
REQ-042 Reset asserted mid-EXEC -> next cycle Ready_to_uf=0, Exec_tag=0, Issue_ready=1, later UF_Done ignored.

Source files
------------

// File: rtl/estacao_reserva_r_if.sv
// Bundled issue, common-data-bus and functional-unit signals of the reservation station.
// The bench drives through the master modport and the station implements the slave modport.
interface estacao_reserva_r_if;
    logic        Issue_valid;
    logic [2:0]  Issue_op;
    logic [15:0] Issue_Vj;
    logic [15:0] Issue_Vk;
    logic [2:0]  Issue_Qj;
    logic [2:0]  Issue_Qk;
    logic        Issue_ready;
    logic [2:0]  Issue_tag;
    logic        CDB_valid;
    logic [2:0]  CDB_tag;
    logic [15:0] CDB_data;
    logic        Ready_to_uf;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  Ufop;
    logic        Clear_uf;
    logic        UF_Done;
    logic [2:0]  Exec_tag;
    logic        Timeout_err;

    modport master (
        output Issue_valid, Issue_op, Issue_Vj, Issue_Vk, Issue_Qj, Issue_Qk,
        output CDB_valid, CDB_tag, CDB_data, UF_Done,
        input  Issue_ready, Issue_tag, Ready_to_uf, A, B, Ufop, Clear_uf, Exec_tag, Timeout_err
    );

    modport slave (
        input  Issue_valid, Issue_op, Issue_Vj, Issue_Vk, Issue_Qj, Issue_Qk,
        input  CDB_valid, CDB_tag, CDB_data, UF_Done,
        output Issue_ready, Issue_tag, Ready_to_uf, A, B, Ufop, Clear_uf, Exec_tag, Timeout_err
    );
endinterface

// File: rtl/estacao_reserva_r.sv
// Tomasulo-style reservation station: entries wait for operands on the CDB, then one
// ready entry at a time is dispatched to the functional unit with a completion timeout.
module estacao_reserva_r #(
    parameter int         NUM_ENTRIES = 2,
    parameter logic [2:0] TAG_BASE    = 3'd1,
    parameter int         TIMEOUT     = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    estacao_reserva_r_if.slave bus
);
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;

    logic [NUM_ENTRIES-1:0] r_busy;
    logic [2:0]             r_op [NUM_ENTRIES];
    logic [15:0]            r_vj [NUM_ENTRIES];
    logic [15:0]            r_vk [NUM_ENTRIES];
    logic [2:0]             r_qj [NUM_ENTRIES];
    logic [2:0]             r_qk [NUM_ENTRIES];

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_exec_idx;
    logic          r_ready_to_uf;
    logic          r_clear_uf;
    logic          r_timeout_err;
    logic [15:0]   r_a;
    logic [15:0]   r_b;
    logic [2:0]    r_ufop;
    logic [2:0]    r_exec_tag;

    logic [NUM_ENTRIES-1:0] w_entry_ready;
    logic                   w_free_any;
    logic                   w_rdy_any;
    logic [IW-1:0]          w_free_idx;
    logic [IW-1:0]          w_rdy_idx;
    logic                   w_issue_accept;
    logic                   w_bypass_j;
    logic                   w_bypass_k;
    logic                   w_exec_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_ready
            assign w_entry_ready[gi] = r_busy[gi] && (r_qj[gi] == 3'd0) && (r_qk[gi] == 3'd0);
        end
    endgenerate

    // Descending scan leaves the lowest matching index in each encoder.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_rdy_any  = 1'b0;
        w_rdy_idx  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IW'(i);
            end
            if (w_entry_ready[i]) begin
                w_rdy_any = 1'b1;
                w_rdy_idx = IW'(i);
            end
        end
    end

    // Only opcodes 010, 011, 110 and 111 are legal; they share bit 1 set.
    assign w_issue_accept = bus.Issue_valid && w_free_any && bus.Issue_op[1];
    assign w_bypass_j     = bus.CDB_valid && (bus.Issue_Qj != 3'd0) && (bus.CDB_tag == bus.Issue_Qj);
    assign w_bypass_k     = bus.CDB_valid && (bus.Issue_Qk != 3'd0) && (bus.CDB_tag == bus.Issue_Qk);
    assign w_exec_done    = (r_state == S_EXEC) && (bus.UF_Done || (r_count == LAST_CNT));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_busy[i] <= 1'b0;
                r_op[i]   <= 3'd0;
                r_vj[i]   <= 16'd0;
                r_vk[i]   <= 16'd0;
                r_qj[i]   <= 3'd0;
                r_qk[i]   <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_issue_accept && (w_free_idx == IW'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_op[i]   <= bus.Issue_op;
                    r_vj[i]   <= w_bypass_j ? bus.CDB_data : bus.Issue_Vj;
                    r_qj[i]   <= w_bypass_j ? 3'd0 : bus.Issue_Qj;
                    r_vk[i]   <= w_bypass_k ? bus.CDB_data : bus.Issue_Vk;
                    r_qk[i]   <= w_bypass_k ? 3'd0 : bus.Issue_Qk;
                end else begin
                    if (w_exec_done && (r_exec_idx == IW'(i)))
                        r_busy[i] <= 1'b0;
                    if (r_busy[i] && bus.CDB_valid && (r_qj[i] != 3'd0) && (r_qj[i] == bus.CDB_tag)) begin
                        r_vj[i] <= bus.CDB_data;
                        r_qj[i] <= 3'd0;
                    end
                    if (r_busy[i] && bus.CDB_valid && (r_qk[i] != 3'd0) && (r_qk[i] == bus.CDB_tag)) begin
                        r_vk[i] <= bus.CDB_data;
                        r_qk[i] <= 3'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_exec_idx    <= '0;
            r_ready_to_uf <= 1'b0;
            r_clear_uf    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_a           <= 16'd0;
            r_b           <= 16'd0;
            r_ufop        <= 3'd0;
            r_exec_tag    <= 3'd0;
        end else begin
            r_clear_uf    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rdy_any) begin
                        r_exec_idx    <= w_rdy_idx;
                        r_a           <= r_vj[w_rdy_idx];
                        r_b           <= r_vk[w_rdy_idx];
                        r_ufop        <= r_op[w_rdy_idx];
                        r_exec_tag    <= TAG_BASE + 3'(w_rdy_idx);
                        r_ready_to_uf <= 1'b1;
                        r_count       <= '0;
                        r_state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_exec_done) begin
                        r_ready_to_uf <= 1'b0;
                        r_clear_uf    <= 1'b1;
                        r_exec_tag    <= 3'd0;
                        r_timeout_err <= !bus.UF_Done;
                        r_state       <= S_CLEAR;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_CLEAR: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Issue_ready = w_free_any;
    assign bus.Issue_tag   = w_free_any ? (TAG_BASE + 3'(w_free_idx)) : 3'd0;
    assign bus.Ready_to_uf = r_ready_to_uf;
    assign bus.A           = r_a;
    assign bus.B           = r_b;
    assign bus.Ufop        = r_ufop;
    assign bus.Clear_uf    = r_clear_uf;
    assign bus.Exec_tag    = r_exec_tag;
    assign bus.Timeout_err = r_timeout_err;
endmodule
